// File: rtl/dev_output_seg_pkg.sv
// Shared register map, CTRL field positions and reset constants for the
// memory-mapped seven-segment output device.
package dev_output_seg_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'b00,
        ADDR_CTRL   = 2'b01,
        ADDR_STATUS = 2'b10,
        ADDR_RSVD   = 2'b11
    } addr_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MASK_LO = 8;
    localparam int CTRL_DP_LO   = 16;

    localparam int STAT_IDX_LO  = 0;
    localparam int STAT_FRAME   = 3;

    localparam logic [31:0] CTRL_RST   = 32'h0000_FF01;
    // Only enable, digit mask and dp mask are stored; other CTRL bits read 0.
    localparam logic [31:0] CTRL_WMASK = 32'h00FF_FF01;

    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/dev_output_seg_hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// Zero latency; no flow control.
module dev_output_seg_hex7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/dev_output_seg.sv
// Memory-mapped 8-digit seven-segment output device with DATA/CTRL/STATUS regs.
// Display outputs registered (1 cycle after idx/DATA/CTRL); bus writes never stall.
module dev_output_seg
    import dev_output_seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:2]  add,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_ca
);

    localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [31:0]      data_q, data_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic             frame_q, frame_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       ca_q, ca_d;

    logic       en;
    logic [7:0] dig_mask;
    logic [7:0] dp_mask;
    logic       step;
    logic       w1c;
    logic [3:0] nib;
    logic [6:0] glyph;

    assign en       = ctrl_q[CTRL_EN];
    assign dig_mask = ctrl_q[CTRL_MASK_LO +: 8];
    assign dp_mask  = ctrl_q[CTRL_DP_LO +: 8];
    assign step     = en && (psc_q == PSC_LAST);
    assign w1c      = we && (add == ADDR_STATUS) && data_in[STAT_FRAME];
    assign nib      = data_q[4*idx_q +: 4];

    dev_output_seg_hex7seg u_hex (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        psc_d   = psc_q;
        idx_d   = idx_q;
        an_d    = SEG_OFF;
        ca_d    = SEG_OFF;

        if (we && add == ADDR_DATA) begin
            data_d = data_in;
        end
        if (we && add == ADDR_CTRL) begin
            ctrl_d = data_in & CTRL_WMASK;
        end

        // Disabled scan parks on digit 0 so re-enable gets a full first slot.
        if (!en) begin
            psc_d = '0;
            idx_d = '0;
        end else if (step) begin
            psc_d = '0;
            idx_d = idx_q + 1'b1;
        end else begin
            psc_d = psc_q + 1'b1;
        end

        // A frame wrap in the same cycle as a W1C clear leaves the flag set.
        frame_d = (step && idx_q == IDX_LAST) | (frame_q & ~w1c);

        if (en) begin
            if (dig_mask[idx_q]) begin
                an_d = ~(8'h01 << idx_q);
            end
            ca_d = {~dp_mask[idx_q], glyph};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            ctrl_q  <= CTRL_RST;
            frame_q <= 1'b0;
            psc_q   <= '0;
            idx_q   <= '0;
            an_q    <= SEG_OFF;
            ca_q    <= SEG_OFF;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            frame_q <= frame_d;
            psc_q   <= psc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (add)
            ADDR_DATA:   data_out = data_q;
            ADDR_CTRL:   data_out = ctrl_q;
            ADDR_STATUS: data_out = {28'b0, frame_q, idx_q};
            default:     data_out = '0;
        endcase
    end

    assign seg_an = an_q;
    assign seg_ca = ca_q;

endmodule

// File: tb/tb_dev_output_seg.sv
// Directed bench for dev_output_seg with SCAN_DIV=4 and hand-computed vectors.
module tb_dev_output_seg;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:2]  add;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_ca;

    int n_vec = 0;
    int n_err = 0;

    // Active-low patterns for "1".."8" with dp off.
    logic [7:0] ca_dig [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    logic [7:0] one8 = 8'h01;
    logic [31:0] v;

    dev_output_seg #(.SCAN_DIV(4), .DIGITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .add      (add),
        .data_in  (data_in),
        .data_out (data_out),
        .seg_an   (seg_an),
        .seg_ca   (seg_ca)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; add = a; data_in = d;
        tick();
        we = 1'b0; data_in = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        add = a;
        #1;
        d = data_out;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; add = 2'b00; data_in = '0;

        // 1. reset state
        tick(); tick();
        reset = 1'b0;
        rd(2'b00, v); chk("rst_data", v, 32'h0);
        rd(2'b01, v); chk("rst_ctrl", v, 32'h0000_FF01);
        rd(2'b10, v); chk("rst_status", v, 32'h0);
        chk("rst_an", {24'h0, seg_an}, 32'hFF);
        chk("rst_ca", {24'h0, seg_ca}, 32'hFF);
        tick();
        chk("first_an", {24'h0, seg_an}, 32'hFE);
        chk("first_ca", {24'h0, seg_ca}, 32'hC0);

        // 2. write DATA then follow a whole frame from a clean restart
        wr(2'b01, 32'h0);
        wr(2'b00, 32'h8765_4321);
        chk("dis_an", {24'h0, seg_an}, 32'hFF);
        wr(2'b01, 32'h0000_FF01);
        for (int t = 1; t <= 32; t++) begin
            tick();
            chk("scan_an", {24'h0, seg_an}, {24'h0, ~(one8 << ((t - 1) / 4))});
            chk("scan_ca", {24'h0, seg_ca}, {24'h0, ca_dig[(t - 1) / 4]});
            if (t == 28) begin
                rd(2'b10, v); chk("stat_idx7", v, 32'h7);
            end
            if (t == 32) begin
                rd(2'b10, v); chk("stat_wrap", v, 32'h8);
            end
        end

        // 3. digit mask 0x0F, dp only on digit 0
        wr(2'b01, 32'h0);
        wr(2'b01, 32'h0001_0F01);
        for (int t = 1; t <= 32; t++) begin
            tick();
            chk("mask_an", {24'h0, seg_an},
                ((t - 1) / 4 < 4) ? {24'h0, ~(one8 << ((t - 1) / 4))} : 32'hFF);
            chk("mask_ca", {24'h0, seg_ca},
                ((t - 1) / 4 == 0) ? 32'h79 : {24'h0, ca_dig[(t - 1) / 4]});
        end

        // 4. disable mid-scan at idx=5, then re-enable
        wr(2'b01, 32'h0);
        wr(2'b10, 32'h8);
        wr(2'b01, 32'h0000_FF01);
        for (int t = 1; t <= 21; t++) tick();
        rd(2'b10, v); chk("pre_dis_idx", v, 32'h5);
        wr(2'b01, 32'h0000_FF00);
        tick();
        chk("dis_an2", {24'h0, seg_an}, 32'hFF);
        chk("dis_ca2", {24'h0, seg_ca}, 32'hFF);
        rd(2'b10, v); chk("dis_status", v, 32'h0);
        wr(2'b01, 32'h0000_FF01);
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("reen_an", {24'h0, seg_an}, (t <= 4) ? 32'hFE : 32'hFD);
            chk("reen_ca", {24'h0, seg_ca}, (t <= 4) ? 32'hF9 : 32'hA4);
        end

        // 5. W1C landing on the frame wrap edge, then a plain clear
        wr(2'b01, 32'h0);
        wr(2'b01, 32'h0000_FF01);
        for (int t = 1; t <= 31; t++) tick();
        rd(2'b10, v); chk("race_pre", v, 32'h7);
        wr(2'b10, 32'h8);
        rd(2'b10, v); chk("race_set_wins", v, 32'h8);
        tick(); tick();
        wr(2'b10, 32'h8);
        rd(2'b10, v); chk("w1c_clear", v, 32'h0);

        // 6. reserved address and CTRL write masking
        wr(2'b11, 32'hFFFF_FFFF);
        rd(2'b11, v); chk("rsvd_rd", v, 32'h0);
        rd(2'b00, v); chk("rsvd_no_data", v, 32'h8765_4321);
        wr(2'b01, 32'hFFFF_FFFF);
        rd(2'b01, v); chk("ctrl_mask", v, 32'h00FF_FF01);

        // 7. reset during an active scan
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'b00, v); chk("rst2_data", v, 32'h0);
        rd(2'b01, v); chk("rst2_ctrl", v, 32'h0000_FF01);
        rd(2'b10, v); chk("rst2_status", v, 32'h0);
        chk("rst2_an", {24'h0, seg_an}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dev_output_seg.md
Name: dev_output_seg

Overview:
Memory-mapped output device. It is the write-side counterpart of the bus input port: the CPU stores a 32-bit value and control word into it over the same word-addressed device bus (add[3:2]). The block time-multiplexes the eight hex nibbles onto a common-anode 8-digit seven-segment display. It sits on the device bus beside the input port, and its registers can be read back by the CPU.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is lit (≥2); benches use 4
DIGITS, 8, number of display digits, fixed at 8 (nibble count of DATA)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
we  input  1  CPU write strobe for this device
add  input  2 ([3:2])  word select: 00 DATA, 01 CTRL, 10 STATUS, 11 reserved
data_in  input  32  CPU write data
data_out  output  32  readback of the selected register (combinational)
seg_an  output  8  digit anodes, active-low, bit i = digit i
seg_ca  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Single clock. Reset is synchronous and active-high: it is sampled only on the rising edge of clk.
- Reset values:
  - DATA = 0
  - CTRL = 32'h0000_FF01
  - STATUS sticky bit = 0
  - prescaler = 0
  - digit index = 0
  - seg_an = 8'hFF
  - seg_ca = 8'hFF
- Writes: on a clk edge with we=1, the register selected by add is updated.
  - DATA takes all 32 bits.
  - CTRL keeps only bits [0] (enable), [15:8] (digit mask) and [23:16] (dp mask). All other bits read as 0.
  - STATUS: writing 1 to bit[3] clears frame_done. Every other STATUS bit is read-only.
  - add=11: the write is ignored.
- Reads: data_out = DATA, CTRL, or {28'b0, frame_done, idx[2:0]} according to add. Reserved address reads 0. The read path is independent of we.
- Scan counter:
  - When enable=1, the prescaler counts 0..SCAN_DIV-1.
  - At terminal count the prescaler returns to 0 and idx increments mod 8.
  - On the idx wrap 7→0, frame_done is set (sticky).
- Enable=0:
  - prescaler and idx are held at 0.
  - The registered outputs become seg_an=8'hFF and seg_ca=8'hFF on the next edge.
  - Re-enabling restarts at digit 0 with a full SCAN_DIV period.
- Output stage:
  - seg_an and seg_ca are registered. They reflect idx, DATA and CTRL as of the previous edge, i.e. one cycle of latency.
  - seg_an drives only bit idx low, and only if mask[idx]=1; otherwise all anodes are high.
  - seg_ca[6:0] = hex decode of DATA[4*idx+3:4*idx], active-low, standard glyphs 0-9 and A,b,C,d,E,F.
  - seg_ca[7] = ~dpmask[idx].
- Simultaneous events:
  - A W1C clear in the same cycle as a frame wrap: set wins, and frame_done stays 1.
  - A DATA write in the same cycle as a digit step: the new digit shows the new data one cycle later.
- A reset during a scan returns the block to the reset state on that edge. Register contents are lost.

Decomposition:
- Shared header (dev_defs.vh):
  - address codes ADDR_DATA=2'b00, ADDR_CTRL=2'b01, ADDR_STATUS=2'b10
  - CTRL bit positions (EN=0, MASK=15:8, DP=23:16)
  - STATUS bit positions (IDX=2:0, FRAME=3)
  - CTRL reset constant
- One sub-module, hex7seg: a 4-bit nibble in, an active-low 7-bit segment pattern out, purely combinational. It is instantiated once and fed the muxed nibble.
- Register file, prescaler, index and output registers stay in dev_output_seg.

Test Plan:
1. Reset check (SCAN_DIV=4): assert reset 2 cycles, then read each address. Required: DATA=0, CTRL=32'h0000_FF01, STATUS=0. One cycle after reset deasserts: seg_an=8'hFE and seg_ca=8'hC0 (glyph "0").
2. Write-then-scan: write DATA=32'h8765_4321, then track the scan. Each digit is held 4 cycles. seg_an steps FE,FD,FB,...,7F. seg_ca follows 8'hF9 ("1"), 8'hA4 ("2"), ... , 8'h80 ("8"). After the first wrap, STATUS bit3 reads 1.
3. Mask and dp: write CTRL=32'h0001_0F01. Required: digits 4-7 show seg_an=8'hFF during their slots. Digit 0 shows seg_ca[7]=0. All other digits show dp high.
4. Disable/re-enable: write CTRL bit0=0 mid-scan at idx=5. Required: the next edge gives seg_an=8'hFF, and STATUS idx reads 0. Re-enable gives digit 0 for a full 4 cycles.
5. W1C race: hold idx=7 with the prescaler at 3, and write STATUS=32'h8 on that edge. Required: frame_done stays 1. A write of 32'h8 on a later non-wrap cycle clears it to 0.
6. Reserved and partial writes: write 32'hFFFF_FFFF to add=11 and to CTRL. Required: add=11 reads 0, and CTRL reads 32'h00FF_FF01.
